shot_clock_ctrl: RTL and testbench

24-second shot-clock controller for the basketball scoreboard. It turns the divider's 1 Hz toggle output into a once-per-second pulse and counts down from a reloadable value in two BCD digits. It takes single-cycle command pulses from the debounce stage and drives the seconds digits, run/expired status and buzzer toward the display scanner and buzzer driver. Clocked on the 100 MHz system clock, not on the divided clocks.

---
 rtl/shot_clock_ctrl.sv | 119 +++++++++++
 tb/tb_shot_clock_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/shot_clock_ctrl.sv
// shot_clock_ctrl: 24-second shot clock for the scoreboard.
// Converts the free-running 1 Hz toggle into a one-cycle second pulse and
// counts down a two-digit BCD value, reloadable to a full or short value.
// Expiry holds the digits at 00 and sounds the buzzer for BUZZ_SEC seconds.
//
// Ports:
//   clk               100 MHz system clock
//   rst               asynchronous active-high reset
//   tick_1hz          1 Hz square wave, asynchronous to clk
//   btn_start_pause   1-cycle pulse, toggles run/pause
//   btn_reload_full   1-cycle pulse, load RELOAD_FULL
//   btn_reload_short  1-cycle pulse, load RELOAD_SHORT
//   secs_tens/ones    BCD remaining seconds
//   running           state == RUN (registered)
//   expired           state == EXPIRED (registered)
//   buzzer            buzzer enable
module shot_clock_ctrl #(
  parameter int RELOAD_FULL  = 24,
  parameter int RELOAD_SHORT = 14,
  parameter int BUZZ_SEC     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_start_pause,
  input  logic       btn_reload_full,
  input  logic       btn_reload_short,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       running,
  output logic       expired,
  output logic       buzzer
);

  localparam logic [3:0] FULL_T  = 4'(RELOAD_FULL / 10);
  localparam logic [3:0] FULL_O  = 4'(RELOAD_FULL % 10);
  localparam logic [3:0] SHORT_T = 4'(RELOAD_SHORT / 10);
  localparam logic [3:0] SHORT_O = 4'(RELOAD_SHORT % 10);
  localparam logic [3:0] BUZZ_V  = 4'(BUZZ_SEC);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t     state;
  logic       sync1, sync2, sync3;
  logic       sec_pulse;
  logic [3:0] buzz_cnt;
  logic       at_one, at_zero;

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= tick_1hz;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign sec_pulse = sync2 & ~sync3;
  assign at_one    = (secs_tens == 4'd0) && (secs_ones == 4'd1);
  assign at_zero   = (secs_tens == 4'd0) && (secs_ones == 4'd0);

  // Priority: reload_full > reload_short > start_pause > sec_pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      secs_tens <= FULL_T;
      secs_ones <= FULL_O;
      running   <= 1'b0;
      expired   <= 1'b0;
      buzzer    <= 1'b0;
      buzz_cnt  <= 4'd0;
    end else if (btn_reload_full || btn_reload_short) begin
      secs_tens <= btn_reload_full ? FULL_T : SHORT_T;
      secs_ones <= btn_reload_full ? FULL_O : SHORT_O;
      // Reload leaves other states alone; only expiry is cleared back to idle.
      if (state == EXPIRED) begin
        state    <= IDLE;
        expired  <= 1'b0;
        buzzer   <= 1'b0;
        buzz_cnt <= 4'd0;
      end
    end else if (btn_start_pause && state != EXPIRED) begin
      if (state == RUN) begin
        state   <= PAUSE;
        running <= 1'b0;
      end else begin
        state   <= RUN;
        running <= 1'b1;
      end
    end else if (sec_pulse) begin
      if (state == RUN) begin
        if (!at_zero) begin
          if (secs_ones == 4'd0) begin
            secs_ones <= 4'd9;
            secs_tens <= secs_tens - 4'd1;
          end else begin
            secs_ones <= secs_ones - 4'd1;
          end
        end
        // 00 in RUN cannot be reached through reloads, but expire rather than wrap.
        if (at_one || at_zero) begin
          state    <= EXPIRED;
          running  <= 1'b0;
          expired  <= 1'b1;
          buzzer   <= 1'b1;
          buzz_cnt <= BUZZ_V;
        end
      end else if (state == EXPIRED && buzz_cnt != 4'd0) begin
        buzz_cnt <= buzz_cnt - 4'd1;
        if (buzz_cnt == 4'd1) buzzer <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Scoreboard bench for shot_clock_ctrl: expected output words are queued as
// stimulus is driven and popped when the resulting outputs are sampled.
module tb_shot_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick_1hz;
  logic       btn_start_pause, btn_reload_full, btn_reload_short;
  logic [3:0] secs_tens, secs_ones;
  logic       running, expired, buzzer;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  shot_clock_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .tick_1hz         (tick_1hz),
    .btn_start_pause  (btn_start_pause),
    .btn_reload_full  (btn_reload_full),
    .btn_reload_short (btn_reload_short),
    .secs_tens        (secs_tens),
    .secs_ones        (secs_ones),
    .running          (running),
    .expired          (expired),
    .buzzer           (buzzer)
  );

  // Packed output word: {tens, ones, running, expired, buzzer}.
  function automatic logic [10:0] st(input int s, input bit r, input bit e, input bit b);
    logic [3:0] t, o;
    t = 4'(s / 10);
    o = 4'(s % 10);
    return {t, o, r, e, b};
  endfunction

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t,o,run,exp,buz)", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [10:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag);
    logic [10:0] e;
    e = exp_q.pop_front();
    chk(tag, {secs_tens, secs_ones, running, expired, buzzer}, e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rising edge reaches the digits on the 3rd clk edge after it is sampled.
  task automatic tick(input string tag, input logic [10:0] e);
    push(e);
    tick_1hz = 1'b1;
    cyc(3);
    pop_chk(tag);
    cyc(97);
    tick_1hz = 1'b0;
    cyc(100);
  endtask

  // which: 0 start_pause, 1 reload_full, 2 reload_short, 3 both reloads
  task automatic pulse(input int which, input string tag, input logic [10:0] e);
    push(e);
    btn_start_pause  = (which == 0);
    btn_reload_full  = (which == 1) || (which == 3);
    btn_reload_short = (which == 2) || (which == 3);
    cyc(1);
    btn_start_pause  = 1'b0;
    btn_reload_full  = 1'b0;
    btn_reload_short = 1'b0;
    pop_chk(tag);
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0;
    btn_start_pause = 1'b0; btn_reload_full = 1'b0; btn_reload_short = 1'b0;
    cyc(3);
    push(st(24, 0, 0, 0)); pop_chk("rst_hold");
    rst = 1'b0;
    cyc(20);
    push(st(24, 0, 0, 0)); pop_chk("rst_release");

    // Run 24 -> 18, pause through 3 ticks, resume for one.
    pulse(0, "start", st(24, 1, 0, 0));
    for (int i = 23; i >= 18; i--) tick("run_a", st(i, 1, 0, 0));
    pulse(0, "pause", st(18, 0, 0, 0));
    for (int i = 0; i < 3; i++) tick("paused_hold", st(18, 0, 0, 0));
    pulse(0, "resume", st(18, 1, 0, 0));
    tick("resume_dec", st(17, 1, 0, 0));
    for (int i = 16; i >= 10; i--) tick("run_b", st(i, 1, 0, 0));
    tick("borrow_10_09", st(9, 1, 0, 0));

    // reload_short on the same cycle as sec_pulse: load wins, no decrement.
    push(st(9, 1, 0, 0));
    tick_1hz = 1'b1;
    cyc(2);
    pop_chk("pre_reload");
    push(st(14, 1, 0, 0));
    btn_reload_short = 1'b1;
    cyc(1);
    btn_reload_short = 1'b0;
    pop_chk("short_vs_pulse");
    cyc(97); tick_1hz = 1'b0; cyc(100);
    pulse(3, "full_over_short", st(24, 1, 0, 0));

    // Full countdown to expiry; the expiry edge is checked on both sides.
    for (int i = 23; i >= 1; i--) tick("run_c", st(i, 1, 0, 0));
    push(st(1, 1, 0, 0));
    tick_1hz = 1'b1;
    cyc(2);
    pop_chk("pre_expire");
    push(st(0, 0, 1, 1));
    cyc(1);
    pop_chk("expire_edge");
    cyc(97); tick_1hz = 1'b0; cyc(100);
    tick("buzz_1", st(0, 0, 1, 1));
    pulse(1, "reload_in_exp", st(24, 0, 0, 0));
    for (int i = 0; i < 2; i++) tick("idle_hold", st(24, 0, 0, 0));

    // Second expiry: buzzer length and start_pause ignored while expired.
    pulse(0, "start2", st(24, 1, 0, 0));
    for (int i = 23; i >= 1; i--) tick("run_d", st(i, 1, 0, 0));
    tick("expire2", st(0, 0, 1, 1));
    tick("buzz_a", st(0, 0, 1, 1));
    tick("buzz_b", st(0, 0, 1, 1));
    tick("buzz_off", st(0, 0, 1, 0));
    pulse(0, "start_in_exp", st(0, 0, 1, 0));
    tick("exp_hold", st(0, 0, 1, 0));

    // Async reset mid-RUN at 07 with a tick edge inside the synchronizer.
    pulse(1, "reload3", st(24, 0, 0, 0));
    pulse(0, "start3", st(24, 1, 0, 0));
    for (int i = 23; i >= 7; i--) tick("run_e", st(i, 1, 0, 0));
    tick_1hz = 1'b1;
    cyc(1);
    #2 rst = 1'b1;
    #1;
    push(st(24, 0, 0, 0)); pop_chk("async_rst");
    cyc(3);
    rst = 1'b0;
    cyc(150);
    tick_1hz = 1'b0;
    cyc(100);
    push(st(24, 0, 0, 0)); pop_chk("post_rst");
    tick("post_rst_tick", st(24, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
